// File: rtl/wb_arb_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : wb_arb_pkg                                                   |
// | Description : Shared types and constants for the boot/CPU Wishbone arbiter |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // Values driven onto the slave cycle-type lines while nobody owns the bus
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
// +----------------------------------------------------------------------------+
// | Module      : wb_arb_watchdog                                              |
// | Description : Saturating bus-hang counter; fires at TIMEOUT_CYCLES-1.      |
// |               Present only when WB_ARB_TIMEOUT_EN is defined.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 16
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic en,
  input  logic clr,
  output logic fire
);

  localparam logic [TW-1:0] c_fire_at = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_count;

  assign fire = en & (r_count == c_fire_at);

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_count <= '0;
    end else if (clr || fire) begin
      r_count <= '0;
    end else if (en && (r_count != {TW{1'b1}})) begin
      r_count <= r_count + TW'(1);
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/wb_boot_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : wb_boot_arbiter                                              |
// | Description : Two-master Wishbone arbiter; boot engine exclusive during    |
// |               boot, round-robin afterwards. WB_ARB_TIMEOUT_EN adds the     |
// |               bus-hang watchdog.                                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_boot_arbiter
  import wb_arb_pkg::*;
#(
  parameter int WB_DATA        = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TW             = 16
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [WB_DATA-1:0]      m0_adr_i,
  input  logic [WB_DATA-1:0]      m0_dat_i,
  input  logic [(WB_DATA>>3)-1:0] m0_sel_i,
  input  logic                    m0_we_i,
  input  logic                    m0_cyc_i,
  input  logic                    m0_stb_i,
  input  logic [2:0]              m0_cti_i,
  input  logic [1:0]              m0_bte_i,
  output logic [WB_DATA-1:0]      m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  output logic                    m0_rty_o,
  input  logic [WB_DATA-1:0]      m1_adr_i,
  input  logic [WB_DATA-1:0]      m1_dat_i,
  input  logic [(WB_DATA>>3)-1:0] m1_sel_i,
  input  logic                    m1_we_i,
  input  logic                    m1_cyc_i,
  input  logic                    m1_stb_i,
  input  logic [2:0]              m1_cti_i,
  input  logic [1:0]              m1_bte_i,
  output logic [WB_DATA-1:0]      m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic                    m1_rty_o,
  output logic [WB_DATA-1:0]      s_adr_o,
  output logic [WB_DATA-1:0]      s_dat_o,
  output logic [(WB_DATA>>3)-1:0] s_sel_o,
  output logic                    s_we_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic [2:0]              s_cti_o,
  output logic [1:0]              s_bte_o,
  input  logic [WB_DATA-1:0]      s_dat_i,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  input  logic                    boot_active,
  output logic [1:0]              grant,
  output logic                    timeout_event
);

  generate
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > (2**TW) - 1)) begin : g_bad_timeout
      $error("wb_boot_arbiter: TIMEOUT_CYCLES must lie in 2..2**TW-1");
    end
  endgenerate

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       w_req0;
  logic       w_req1;
  logic       w_cyc;
  logic       w_stb;
  logic       w_fire;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // During boot the CPU is held in reset, so its requests are simply ignored
  assign w_req0 = m0_cyc_i;
  assign w_req1 = m1_cyc_i & ~boot_active;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (w_req0 && (!w_req1 || r_last)) begin
          w_state_nxt = OWN0;
        end else if (w_req1) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_state_nxt = IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    w_cyc    = 1'b0;
    w_stb    = 1'b0;
    s_cti_o  = CTI_CLASSIC;
    s_bte_o  = BTE_LINEAR;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    grant    = GRANT_NONE;
    case (r_state)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        w_cyc    = m0_cyc_i;
        w_stb    = m0_stb_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | w_fire;
        m0_rty_o = s_rty_i;
        grant    = m0_cyc_i ? GRANT_M0 : GRANT_NONE;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        w_cyc    = m1_cyc_i;
        w_stb    = m1_stb_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | w_fire;
        m1_rty_o = s_rty_i;
        grant    = m1_cyc_i ? GRANT_M1 : GRANT_NONE;
      end
      default: ;
    endcase
  end

  assign s_cyc_o = w_cyc;
  // The forced err cycle must not also present a live strobe to the slave
  assign s_stb_o = w_stb & ~w_fire;

`ifdef WB_ARB_TIMEOUT_EN
  logic w_resp;
  logic w_wd_en;

  assign w_resp  = s_ack_i | s_err_i | s_rty_i;
  assign w_wd_en = (r_state != IDLE) & w_cyc & w_stb & ~w_resp;

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_watchdog (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .en     (w_wd_en),
    .clr    (~w_wd_en),
    .fire   (w_fire)
  );
`else
  assign w_fire = 1'b0;
`endif

  assign timeout_event = w_fire;

endmodule

`default_nettype wire

// File: tb/tb_wb_boot_arbiter.sv
// Self-checking bench for wb_boot_arbiter: scoreboard of expected slave-side
// transfers plus direct checks of grant, responses and watchdog behaviour.
`default_nettype none

module tb_wb_boot_arbiter;
  import wb_arb_pkg::*;

  localparam int WB_DATA = 32;

  typedef struct packed {
    logic [1:0]  grant;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic        boot_active;
  logic [1:0]  grant;
  logic        timeout_event;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  wb_boot_arbiter #(
    .WB_DATA        (WB_DATA),
    .TIMEOUT_CYCLES (8),
    .TW             (16)
  ) dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .m0_adr_i      (m0_adr_i),
    .m0_dat_i      (m0_dat_i),
    .m0_sel_i      (m0_sel_i),
    .m0_we_i       (m0_we_i),
    .m0_cyc_i      (m0_cyc_i),
    .m0_stb_i      (m0_stb_i),
    .m0_cti_i      (m0_cti_i),
    .m0_bte_i      (m0_bte_i),
    .m0_dat_o      (m0_dat_o),
    .m0_ack_o      (m0_ack_o),
    .m0_err_o      (m0_err_o),
    .m0_rty_o      (m0_rty_o),
    .m1_adr_i      (m1_adr_i),
    .m1_dat_i      (m1_dat_i),
    .m1_sel_i      (m1_sel_i),
    .m1_we_i       (m1_we_i),
    .m1_cyc_i      (m1_cyc_i),
    .m1_stb_i      (m1_stb_i),
    .m1_cti_i      (m1_cti_i),
    .m1_bte_i      (m1_bte_i),
    .m1_dat_o      (m1_dat_o),
    .m1_ack_o      (m1_ack_o),
    .m1_err_o      (m1_err_o),
    .m1_rty_o      (m1_rty_o),
    .s_adr_o       (s_adr_o),
    .s_dat_o       (s_dat_o),
    .s_sel_o       (s_sel_o),
    .s_we_o        (s_we_o),
    .s_cyc_o       (s_cyc_o),
    .s_stb_o       (s_stb_o),
    .s_cti_o       (s_cti_o),
    .s_bte_o       (s_bte_o),
    .s_dat_i       (s_dat_i),
    .s_ack_i       (s_ack_i),
    .s_err_i       (s_err_i),
    .s_rty_i       (s_rty_i),
    .boot_active   (boot_active),
    .grant         (grant),
    .timeout_event (timeout_event)
  );

  always #5 wb_clk = ~wb_clk;

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic sb_push(input logic [1:0] g, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.grant = g;
    e.adr   = a;
    e.dat   = d;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check({tag, "_grant"}, 32'(grant), 32'(e.grant));
      check({tag, "_adr"}, s_adr_o, e.adr);
      check({tag, "_dat"}, s_dat_o, e.dat);
    end
  endtask

  task automatic drive_m0(input logic c, input logic [31:0] a, input logic [31:0] d);
    m0_cyc_i = c; m0_stb_i = c; m0_we_i = c; m0_adr_i = a; m0_dat_i = d;
  endtask

  task automatic drive_m1(input logic c, input logic [31:0] a, input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = c; m1_we_i = c; m1_adr_i = a; m1_dat_i = d;
  endtask

  initial begin
    logic seen_err;
    logic seen_to;
    wb_rst = 1'b1;
    boot_active = 1'b0;
    drive_m0(1'b0, '0, '0);
    drive_m1(1'b0, '0, '0);
    m0_sel_i = 4'hF; m1_sel_i = 4'hF;
    m0_cti_i = 3'b000; m1_cti_i = 3'b000;
    m0_bte_i = 2'b00; m1_bte_i = 2'b00;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_grant", 32'(grant), 32'(GRANT_NONE));
    check("rst_s_cyc", 32'(s_cyc_o), 32'(0));
    check("rst_s_stb", 32'(s_stb_o), 32'(0));
    check("rst_timeout", 32'(timeout_event), 32'(0));
    wb_rst = 1'b0;

    // Boot exclusivity
    tick();
    boot_active = 1'b1;
    drive_m0(1'b1, 32'h9200_0000, 32'hDEAD_BEEF);
    drive_m1(1'b1, 32'h3000_0000, 32'h1111_1111);
    sb_push(GRANT_M0, 32'h9200_0000, 32'hDEAD_BEEF);
    settle();
    check("arb_latency_grant", 32'(grant), 32'(GRANT_NONE));
    check("arb_latency_cyc", 32'(s_cyc_o), 32'(0));
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
    settle();
    check("boot_s_cyc", 32'(s_cyc_o), 32'(1));
    sb_check("boot_m0");
    check("boot_m0_ack", 32'(m0_ack_o), 32'(1));
    check("boot_m0_dat", m0_dat_o, 32'hCAFE_F00D);
    check("boot_m1_ack", 32'(m1_ack_o), 32'(0));
    check("boot_m1_dat", m1_dat_o, 32'h0);
    tick();
    s_ack_i = 1'b0; s_dat_i = '0;
    drive_m0(1'b0, '0, '0);
    settle();
    check("release_grant", 32'(grant), 32'(GRANT_NONE));
    check("release_s_cyc", 32'(s_cyc_o), 32'(0));
    tick(); tick();
    check("boot_blocks_m1_grant", 32'(grant), 32'(GRANT_NONE));
    check("boot_blocks_m1_ack", 32'(m1_ack_o), 32'(0));
    boot_active = 1'b0;
    sb_push(GRANT_M1, 32'h3000_0000, 32'h1111_1111);
    settle();
    tick();
    s_ack_i = 1'b1;
    settle();
    sb_check("after_boot_m1");
    check("after_boot_m1_ack", 32'(m1_ack_o), 32'(1));
    tick();
    s_ack_i = 1'b0;
    drive_m1(1'b0, '0, '0);
    settle();

    // Round-robin: m1 was last, so the ties go m0, m1, m0, m1
    for (int k = 0; k < 4; k++) begin
      tick();
      drive_m0(1'b1, 32'h1000_0000 + k, 32'hA0 + k);
      drive_m1(1'b1, 32'h2000_0000 + k, 32'hB0 + k);
      if (k % 2 == 0) sb_push(GRANT_M0, 32'h1000_0000 + k, 32'hA0 + k);
      else            sb_push(GRANT_M1, 32'h2000_0000 + k, 32'hB0 + k);
      settle();
      check("rr_idle_grant", 32'(grant), 32'(GRANT_NONE));
      tick();
      s_ack_i = 1'b1;
      settle();
      sb_check("rr");
      check("rr_m0_ack", 32'(m0_ack_o), 32'(k % 2 == 0));
      check("rr_m1_ack", 32'(m1_ack_o), 32'(k % 2 == 1));
      tick();
      s_ack_i = 1'b0;
      if (k % 2 == 0) drive_m0(1'b0, '0, '0);
      else            drive_m1(1'b0, '0, '0);
      settle();
      check("rr_release_grant", 32'(grant), 32'(GRANT_NONE));
    end
    drive_m0(1'b0, '0, '0);

    // Ownership held across a stb gap
    tick();
    drive_m1(1'b1, 32'h0000_0040, 32'h0000_0044);
    settle();
    tick();
    drive_m0(1'b1, 32'h0000_0050, 32'h0000_0055);
    m1_stb_i = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      check("hold_gap_grant", 32'(grant), 32'(GRANT_M1));
      check("hold_gap_stb", 32'(s_stb_o), 32'(0));
      check("hold_gap_m0_ack", 32'(m0_ack_o), 32'(0));
      tick();
    end
    m1_stb_i = 1'b1;
    sb_push(GRANT_M1, 32'h0000_0040, 32'h0000_0044);
    s_ack_i = 1'b1;
    settle();
    sb_check("hold_reissue");
    check("hold_m1_ack", 32'(m1_ack_o), 32'(1));
    check("hold_m0_ack", 32'(m0_ack_o), 32'(0));
    tick();
    s_ack_i = 1'b0;
    drive_m1(1'b0, '0, '0);
    settle();
    tick();
    sb_push(GRANT_M0, 32'h0000_0050, 32'h0000_0055);
    settle();
    tick();
    s_ack_i = 1'b1;
    settle();
    sb_check("hold_m0_served");
    tick();
    s_ack_i = 1'b0;
    drive_m0(1'b0, '0, '0);
    settle();

    // Silent slave
    tick();
    drive_m0(1'b1, 32'h0000_0060, 32'h0000_0066);
    settle();
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      check("wd_err", 32'(m0_err_o), 32'(i == 8));
      check("wd_event", 32'(timeout_event), 32'(i == 8));
      check("wd_stb", 32'(s_stb_o), 32'(i != 8));
      check("wd_m1_err", 32'(m1_err_o), 32'(0));
      if (i < 8) tick();
    end
    tick();
    drive_m0(1'b0, '0, '0);
    settle();
    tick();
    drive_m0(1'b1, 32'h0000_0064, 32'h0000_0068);
    settle();
    tick();
    for (int i = 1; i < 8; i++) begin
      check("wd_late_pre_err", 32'(m0_err_o), 32'(0));
      tick();
    end
    s_ack_i = 1'b1;
    sb_push(GRANT_M0, 32'h0000_0064, 32'h0000_0068);
    settle();
    check("wd_late_err", 32'(m0_err_o), 32'(0));
    check("wd_late_event", 32'(timeout_event), 32'(0));
    check("wd_late_ack", 32'(m0_ack_o), 32'(1));
    sb_check("wd_late");
`else
    seen_err = 1'b0;
    seen_to  = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      seen_err = seen_err | m0_err_o;
      seen_to  = seen_to | timeout_event;
      tick();
    end
    check("off_no_err", 32'(seen_err), 32'(0));
    check("off_no_event", 32'(seen_to), 32'(0));
    check("off_grant_held", 32'(grant), 32'(GRANT_M0));
    s_ack_i = 1'b1;
    sb_push(GRANT_M0, 32'h0000_0060, 32'h0000_0066);
    settle();
    sb_check("off_final");
`endif
    tick();
    s_ack_i = 1'b0;
    drive_m0(1'b0, '0, '0);
    settle();

    // Asynchronous reset while m0 owns, then first tie goes to m0
    tick();
    drive_m0(1'b1, 32'h0000_0070, 32'h0000_0077);
    settle();
    tick();
    check("pre_rst_grant", 32'(grant), 32'(GRANT_M0));
    #3;
    wb_rst = 1'b1;
    #1;
    check("async_rst_cyc", 32'(s_cyc_o), 32'(0));
    check("async_rst_stb", 32'(s_stb_o), 32'(0));
    check("async_rst_grant", 32'(grant), 32'(GRANT_NONE));
    tick();
    wb_rst = 1'b0;
    drive_m1(1'b1, 32'h0000_0080, 32'h0000_0088);
    sb_push(GRANT_M0, 32'h0000_0070, 32'h0000_0077);
    settle();
    check("post_rst_idle", 32'(grant), 32'(GRANT_NONE));
    tick();
    s_ack_i = 1'b1;
    settle();
    sb_check("post_rst_tie");
    tick();
    s_ack_i = 1'b0;
    drive_m0(1'b0, '0, '0);
    drive_m1(1'b0, '0, '0);
    settle();

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
